// File: rtl/alu_arbiter.sv
// Purpose: arbitrates two requesters onto one shared ALU, with at most one transaction in flight.
// Latency: ALU_LATENCY+1 cycles from grant to rsp_valid. The earliest next grant is the cycle after the response handshake.
// Backpressure: the response is held stable while rsp_ready is low, and no request is accepted until it drains.
//
// Ports: clk, rst (synchronous, active-high)
//        req{0,1}_valid/_ready/_a/_b/_op : request side
//        alu_a/alu_b/alu_op (registered) and alu_c : shared ALU
//        rsp_valid/rsp_ready/rsp_id/rsp_data : response side
//        busy : high whenever the FSM is not in IDLE
// Config: define ALU_ARBITER_FIXED_PRIO_EN for fixed priority (req0 wins contention).
//         That build has no round-robin pointer.
module alu_arbiter #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_a,
    input  logic [3:0]        req0_b,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_a,
    input  logic [3:0]        req1_b,
    input  logic [1:0]        req1_op,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [1:0]        alu_op,
    input  logic signed [5:0] alu_c,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic signed [5:0] rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);
    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        alu_a_q, alu_a_d;
    logic [3:0]        alu_b_q, alu_b_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic signed [5:0] rsp_data_q, rsp_data_d;
    logic              grant0, grant1;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
    end
`else
    // rr_ptr names the requester that wins the next contended cycle.
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~rr_ptr_q);
        grant1 = req1_valid & (~req0_valid | rr_ptr_q);
    end

    // The pointer moves only on an accepted grant, so a requester that drops early leaves no trace.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (req0_ready) begin
            rr_ptr_d = 1'b1;
        end else if (req1_ready) begin
            rr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // The readies are gated with rst, so nothing is accepted on a reset edge.
    assign req0_ready = (state_q == IDLE) & ~rst & grant0;
    assign req1_ready = (state_q == IDLE) & ~rst & grant1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    alu_a_d  = req0_a;
                    alu_b_d  = req0_b;
                    alu_op_d = req0_op;
                    rsp_id_d = 1'b0;
                    cnt_d    = LAT;
                    state_d  = EXEC;
                end else if (req1_ready) begin
                    alu_a_d  = req1_a;
                    alu_b_d  = req1_b;
                    alu_op_d = req1_op;
                    rsp_id_d = 1'b1;
                    cnt_d    = LAT;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 3'd1;
                // Capture on the cycle the counter reaches zero.
                // The <= also guards against a zero load.
                if (cnt_q <= 3'd1) begin
                    cnt_d       = 3'd0;
                    rsp_data_d  = alu_c;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_op_q    <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 6'sd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, checked against a
// transaction-level model (grant cycle number + latched operands) on every falling edge.
module tb_alu_arbiter;
    localparam int L = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [5:0] alu_c;
    logic       rsp_valid, rsp_id, rsp_ready, busy;
    logic [5:0] rsp_data;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // Reference ALU: 4-bit unsigned operands, 6-bit two's-complement result.
    function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [5:0] ea;
        logic [5:0] eb;
        ea = {2'b00, a};
        eb = {2'b00, b};
        case (op)
            2'b00:   return ea + eb;
            2'b01:   return ea - eb;
            2'b10:   return ea & eb;
            default: return ea | eb;
        endcase
    endfunction

    assign alu_c = alu_f(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Winner among the valid requesters; ptr names the preferred one on contention.
    function automatic int pick(input logic v0, input logic v1, input bit ptr);
        if (v0 && v1) return ptr ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Transaction model: which posedge granted, who won, and what operands were latched.
    int         cyc = 0;
    int         m_g = 0;
    bit         m_inflight = 1'b0;
    bit         m_ptr = 1'b0;
    bit         m_id = 1'b0;
    logic [3:0] m_a = 4'd0;
    logic [3:0] m_b = 4'd0;
    logic [1:0] m_op = 2'd0;

    always @(posedge clk) begin : model
        int g;
        if (rst) begin
            m_inflight = 1'b0;
            m_ptr = 1'b0;
            m_a = 4'd0;
            m_b = 4'd0;
            m_op = 2'd0;
            m_id = 1'b0;
        end else if (m_inflight) begin
            if (cyc >= m_g + L && rsp_ready) m_inflight = 1'b0;
        end else begin
            g = pick(req0_valid, req1_valid, m_ptr);
            if (g >= 0) begin
                m_a  = (g == 0) ? req0_a : req1_a;
                m_b  = (g == 0) ? req0_b : req1_b;
                m_op = (g == 0) ? req0_op : req1_op;
                m_id = (g == 1);
                m_g  = cyc + 1;
                m_inflight = 1'b1;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
                m_ptr = 1'b0;
`else
                m_ptr = (g == 0);
`endif
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        bit exp_rv;
        int eg;
        if (cmp_en) begin
            exp_rv = m_inflight && (cyc >= m_g + L);
            eg = (m_inflight || rst) ? -1 : pick(req0_valid, req1_valid, m_ptr);
            check("m_busy", busy, m_inflight);
            check("m_req0_ready", req0_ready, eg == 0);
            check("m_req1_ready", req1_ready, eg == 1);
            check("m_alu_a", alu_a, m_a);
            check("m_alu_b", alu_b, m_b);
            check("m_alu_op", alu_op, m_op);
            check("m_rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                check("m_rsp_id", rsp_id, m_id);
                check("m_rsp_data", rsp_data, alu_f(m_a, m_b, m_op));
            end
        end
    end

    // Completed responses as {id, data}.
    logic [6:0] rsp_log[$];
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && rst === 1'b0)
            rsp_log.push_back({rsp_id, rsp_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        forever begin
            settle();
            if (rsp_log.size() >= n) break;
            if (k >= budget) begin
                checks++;
                errors++;
                $display("FAIL wait_log: got %0d responses expected %0d", rsp_log.size(), n);
                break;
            end
            k++;
            tick();
        end
    endtask

    // which: 0 = req0_ready, 1 = req1_ready, 2 = rsp_valid
    task automatic wait_cond(input int which, input string name, input int budget);
        int k = 0;
        forever begin
            settle();
            if ((which == 0 && req0_ready === 1'b1) || (which == 1 && req1_ready === 1'b1) ||
                (which == 2 && rsp_valid === 1'b1)) break;
            if (k >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s: got 0 expected 1 within %0d cycles", name, budget);
                break;
            end
            k++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'd0; req0_b = 4'd0; req0_op = 2'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_op = 2'd0;
        rsp_ready = 1'b1;
        rst = 1'b1;

        // Reset held 5 cycles with both requesters valid: everything stays quiet.
        tick();
        cmp_en = 1'b1;
        repeat (4) tick();
        settle();
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Add on req0 alone: 1 + 9 = 10, valid two cycles after the grant.
        req0_a = 4'd1; req0_b = 4'd9; req0_op = 2'b00; req0_valid = 1'b1;
        wait_cond(0, "add_grant", 10);
        check("add_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        settle();
        check("add_early_valid", rsp_valid, 0);
        check("add_busy", busy, 1);
        tick();
        settle();
        check("add_rsp_valid", rsp_valid, 1);
        check("add_rsp_id", rsp_id, 0);
        check("add_rsp_data", rsp_data, 10);
        tick();
        settle();
        check("add_busy_after", busy, 0);

        // Contention: both held valid from rr_ptr = 0.
        tick();
        do_reset();
        rsp_log.delete();
        req0_a = 4'd15; req0_b = 4'd14; req0_op = 2'b01;
        req1_a = 4'd15; req1_b = 4'd1;  req1_op = 2'b10;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_log(4, 40);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            check("cont_id", rsp_log[i][6], 0);
`else
            check("cont_id", rsp_log[i][6], i % 2);
`endif
            check("cont_data", rsp_log[i][5:0], 1);
        end

        // Backpressure: the response is held 4 cycles with rsp_ready low; req0 waits meanwhile.
        rsp_ready = 1'b0;
        req1_a = 4'd3; req1_b = 4'd5; req1_op = 2'b11; req1_valid = 1'b1;
        wait_cond(1, "bp_grant", 10);
        tick();
        req1_valid = 1'b0;
        req0_a = 4'd4; req0_b = 4'd4; req0_op = 2'b00; req0_valid = 1'b1;
        wait_cond(2, "bp_valid", 10);
        for (int i = 0; i < 4; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_id", rsp_id, 1);
            check("bp_rsp_data", rsp_data, 7);
            check("bp_req0_ready", req0_ready, 0);
            check("bp_req1_ready", req1_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        tick();
        settle();
        check("bp_busy", busy, 0);
        check("bp_rsp_dropped", rsp_valid, 0);

        // Reset pulsed during EXEC: the transaction is aborted and req0 wins next.
        tick();
        rsp_log.delete();
        req0_a = 4'd2; req0_b = 4'd2; req0_op = 2'b00; req0_valid = 1'b1;
        wait_cond(0, "rmo_grant", 10);
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        settle();
        check("rmo_exec_busy", busy, 1);
        check("rmo_exec_valid", rsp_valid, 0);
        tick();
        rst = 1'b0;
        req0_a = 4'd7; req0_b = 4'd2; req0_op = 2'b00; req0_valid = 1'b1;
        req1_a = 4'd1; req1_b = 4'd1; req1_op = 2'b00; req1_valid = 1'b1;
        settle();
        check("rmo_no_valid", rsp_valid, 0);
        check("rmo_req0_ready", req0_ready, 1);
        check("rmo_req1_ready", req1_ready, 0);
        wait_log(1, 10);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rmo_first_rsp", rsp_log[0], {1'b0, 6'd9});

        // Overflow of the 4-bit inputs: 15 + 15 = 30 on req1.
        tick();
        rsp_log.delete();
        req1_a = 4'd15; req1_b = 4'd15; req1_op = 2'b00; req1_valid = 1'b1;
        wait_log(1, 10);
        tick();
        req1_valid = 1'b0;
        check("ovf_rsp", rsp_log[0], {1'b1, 6'd30});

        // Randomized traffic: drops, backpressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst        = ($urandom_range(0, 99) == 0);
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
            rsp_ready  = ($urandom_range(0, 9) < 7);
        end
        tick();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
